// File: rtl/audio_pkg.sv
// audio_pkg: shared magnitude type and fixed-point helpers for the band pipeline
package audio_pkg;
  localparam int MAG_WIDTH = 32;
  typedef logic [MAG_WIDTH-1:0] mag_t;
  // |x| of a w-bit signed value, with the most negative input clamped to 2^(w-1)-1
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x, input int w);
    logic [31:0] a;
    logic [31:0] mx;
    mx = (32'd1 << (w - 1)) - 32'd1;
    a = x[31] ? (~x + 32'd1) : x;
    return a > mx ? mx : a;
  endfunction
  function automatic logic [31:0] ambm(input logic [31:0] a, input logic [31:0] b);
    return a > b ? a + (b >> 1) : b + (a >> 1);
  endfunction
endpackage

// File: rtl/band_magnitude_extractor_cplx_mag_approx.sv
// cplx_mag_approx: two-stage pipelined alpha-max-plus-beta-min magnitude estimate
module cplx_mag_approx
  import audio_pkg::*;
#(
  parameter int IN_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] re_i,
  input  logic [IN_WIDTH-1:0] im_i,
  input  logic                valid_i,
  input  logic                en_i,
  input  logic [1:0]          tag_i,
  output logic [IN_WIDTH:0]   mag_o,
  output logic                valid_o,
  output logic [1:0]          tag_o
);
  logic [IN_WIDTH-1:0] are_d, aim_d, are_q, aim_q;
  logic [IN_WIDTH:0]   mag_d;
  logic                v1_q, en1_q;
  logic [1:0]          tag1_q;
  assign are_d = IN_WIDTH'(abs_sat(32'(signed'(re_i)), IN_WIDTH));
  assign aim_d = IN_WIDTH'(abs_sat(32'(signed'(im_i)), IN_WIDTH));
  assign mag_d = en1_q ? (IN_WIDTH+1)'(ambm(32'(are_q), 32'(aim_q))) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      v1_q    <= valid_i;
      valid_o <= v1_q;
    end
    if (valid_i) begin
      are_q  <= are_d;
      aim_q  <= aim_d;
      en1_q  <= en_i;
      tag1_q <= tag_i;
    end
    if (v1_q) begin
      mag_o <= mag_d;
      tag_o <= tag1_q;
    end
  end
endmodule

// File: rtl/band_magnitude_extractor.sv
// band_magnitude_extractor: sums in-band bin magnitudes of each FFT frame into one saturated band value
module band_magnitude_extractor
  import audio_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int WIDTH    = 32,
  parameter int NUM_BINS = 1024,
  parameter int BIN_LO   = 0,
  parameter int BIN_HI   = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] fft_re,
  input  logic [IN_WIDTH-1:0] fft_im,
  input  logic                fft_valid,
  input  logic                fft_last,
  output logic [WIDTH-1:0]    mag_out,
  output logic                mag_out_valid,
  output logic                frame_err
);
  localparam int CW = $clog2(NUM_BINS) + 1;
  localparam int AW = IN_WIDTH + 1 + $clog2(NUM_BINS);
  localparam int SW = AW > WIDTH ? AW : WIDTH;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IN_WIDTH-1:0] re_q, im_q;
  logic                v_q, last_q, band_q, ok_q, band_d;
  logic [IN_WIDTH:0]   m;
  logic                mv;
  logic [1:0]          tag;
  logic [AW-1:0]       acc_q, acc_d, sum_d;
  logic [SW-1:0]       sum_x;
  logic [WIDTH-1:0]    sat_d;
  // unsigned wrap turns the two-sided range test into a single compare
  assign band_d = (32'(cnt_q) - 32'(BIN_LO)) <= 32'(BIN_HI - BIN_LO);
  assign cnt_d  = fft_last ? '0 : (cnt_q == CW'(2 * NUM_BINS - 1) ? cnt_q : cnt_q + 1'b1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      v_q   <= 1'b0;
    end else begin
      v_q <= fft_valid;
      if (fft_valid) cnt_q <= cnt_d;
    end
    if (fft_valid) begin
      re_q   <= fft_re;
      im_q   <= fft_im;
      last_q <= fft_last;
      band_q <= band_d;
      ok_q   <= cnt_q == CW'(NUM_BINS - 1);
    end
  end
  cplx_mag_approx #(.IN_WIDTH(IN_WIDTH)) u_mag (
    .clk     (clk),
    .rst     (rst),
    .re_i    (re_q),
    .im_i    (im_q),
    .valid_i (v_q),
    .en_i    (band_q),
    .tag_i   ({last_q, ok_q}),
    .mag_o   (m),
    .valid_o (mv),
    .tag_o   (tag)
  );
  assign sum_d = acc_q + AW'(m);
  assign sum_x = SW'(sum_d);
  assign sat_d = |(sum_x >> WIDTH) ? '1 : sum_x[WIDTH-1:0];
  assign acc_d = mv ? (tag[1] ? '0 : sum_d) : acc_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q         <= '0;
      mag_out       <= '0;
      mag_out_valid <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      acc_q         <= acc_d;
      mag_out_valid <= mv && tag[1];
      frame_err     <= mv && tag[1] && !tag[0];
      if (mv && tag[1]) mag_out <= sat_d;
    end
  end
endmodule

// File: tb/tb_band_magnitude_extractor.sv
// tb_band_magnitude_extractor: directed checks of band sums, errors, latency and reset behaviour
module tb_band_magnitude_extractor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] re = '0, im = '0;
  logic        valid = 1'b0, last = 1'b0;
  logic [31:0] mag;
  logic        mv, err;
  logic [15:0] mag16;
  logic        mv16, err16;
  int          nerr = 0, nchk = 0;
  int          q_mag[$];
  int          q_err[$];
  longint      q_t[$];
  int          last16 = -1;
  longint      lt = 0;
  int          base;

  always #5 clk = ~clk;

  band_magnitude_extractor #(.IN_WIDTH(16), .WIDTH(32), .NUM_BINS(8), .BIN_LO(2), .BIN_HI(4)) u32 (
    .clk(clk), .rst(rst), .fft_re(re), .fft_im(im), .fft_valid(valid), .fft_last(last),
    .mag_out(mag), .mag_out_valid(mv), .frame_err(err));
  band_magnitude_extractor #(.IN_WIDTH(16), .WIDTH(16), .NUM_BINS(8), .BIN_LO(2), .BIN_HI(4)) u16 (
    .clk(clk), .rst(rst), .fft_re(re), .fft_im(im), .fft_valid(valid), .fft_last(last),
    .mag_out(mag16), .mag_out_valid(mv16), .frame_err(err16));

  always @(negedge clk) begin
    if (mv) begin
      q_mag.push_back(int'(mag));
      q_err.push_back(int'(err));
      q_t.push_back(longint'($time));
    end
    if (mv16) last16 = int'(mag16) + (err16 ? 1000000 : 0);
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic l, input int r, input int i);
    valid = v;
    last  = l;
    re    = 16'(r);
    im    = 16'(i);
    @(posedge clk);
    if (v && l) lt = longint'($time);
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic frame(input int n, input int r, input int i, input bit gap);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, k == n - 1, r, i);
      if (gap) drive(1'b0, 1'b0, 0, 0);
    end
  endtask

  task automatic check_pulse(input string tag, input int b, input int exp_mag, input int exp_err);
    check({tag, "_count"}, q_mag.size() - b, 1);
    if (q_mag.size() > b) begin
      check({tag, "_mag"}, q_mag[b], exp_mag);
      check({tag, "_err"}, q_err[b], exp_err);
      check({tag, "_lat"}, q_t[b] - lt, 35);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_mag", mag, 0);
    check("rst_valid", mv, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    base = q_mag.size();
    frame(8, 100, -40, 1'b0);
    repeat (6) @(negedge clk);
    check_pulse("nominal", base, 360, 0);

    base = q_mag.size();
    frame(8, -32768, -32768, 1'b0);
    repeat (6) @(negedge clk);
    check_pulse("extreme", base, 147450, 0);
    check("extreme_w16", last16, 65535);

    base = q_mag.size();
    frame(5, 100, -40, 1'b0);
    repeat (6) @(negedge clk);
    check_pulse("short", base, 360, 1);
    base = q_mag.size();
    frame(8, 100, -40, 1'b0);
    repeat (6) @(negedge clk);
    check_pulse("after_short", base, 360, 0);

    base = q_mag.size();
    frame(8, 100, 0, 1'b0);
    frame(8, 10, 10, 1'b0);
    repeat (6) @(negedge clk);
    check("b2b_count", q_mag.size() - base, 2);
    if (q_mag.size() >= base + 2) begin
      check("b2b_mag_a", q_mag[base], 300);
      check("b2b_mag_b", q_mag[base+1], 45);
      check("b2b_spacing", q_t[base+1] - q_t[base], 80);
      check("b2b_lat", q_t[base+1] - lt, 35);
    end

    base = q_mag.size();
    frame(8, 100, -40, 1'b1);
    repeat (6) @(negedge clk);
    check_pulse("gapped", base, 360, 0);

    base = q_mag.size();
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 100, -40);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_mag", mag, 0);
    check("midrst_valid", mv, 0);
    check("midrst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("postrst_mag", mag, 0);
    check("postrst_pulses", q_mag.size() - base, 0);
    base = q_mag.size();
    frame(8, 100, -40, 1'b0);
    repeat (6) @(negedge clk);
    check_pulse("postrst_frame", base, 360, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
